membrane_integrator: RTL
========================

Name: membrane_integrator

Overview:
- Downstream consumer of the ion-current stages (sodium, potassium, leak) in the Hodgkin-Huxley neuron datapath.
- Sums the ionic currents against the external stimulus current and applies one forward-Euler step to the membrane potential: V += (I_ext − I_Na − I_K − I_L)·dt/C_m.
- Registers V, which feeds back to the gating and current stages.
- Flags upward threshold crossings as spikes, with a refractory hold-off.

Parameters:
- V_REST, -16640, reset membrane potential, Q8.8 mV (−65.0).
- V_MIN, -25600, lower clamp on V, Q8.8 (−100.0).
- V_MAX, 20480, upper clamp on V, Q8.8 (+80.0).
- SPIKE_THRESH, 0, spike threshold, Q8.8 (0.0 mV).
- INV_CM, 256, reciprocal membrane capacitance, unsigned Q8.8 (1.0).
- REFRACT_STEPS, 4, accepted steps after a spike during which no new spike is flagged.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  current set and dt are valid.
- in_ready  out  1  block can accept a step.
- i_na  in  16  signed Q8.8 sodium current.
- i_k  in  16  signed Q8.8 potassium current.
- i_leak  in  16  signed Q8.8 leak current.
- i_ext  in  16  signed Q8.8 external stimulus current.
- dt  in  16  unsigned Q8.8 time step, ms.
- v_mem  out  16  signed Q8.8 membrane potential (registered).
- v_valid  out  1  one-cycle pulse: v_mem was just updated.
- spike  out  1  one-cycle pulse, coincident with v_valid.
- refractory  out  1  high while the refractory counter is nonzero.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: v_mem=V_REST, in_ready=1, v_valid=0, spike=0, refractory=0, refractory counter=0, FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0, capture all inputs, go to SUM.
  - SUM: net = i_ext − i_na − i_k − i_leak, computed in 18 bits, saturated to 16-bit signed. Go to SCALE.
  - SCALE: p = net·dt (32-bit signed×unsigned), arithmetic shift right by 8, saturate to 16. Go to UPDATE.
  - UPDATE: dv = p·INV_CM >>> 8, saturated. v_new = v_mem + dv, then clamped to [V_MIN,V_MAX]. Register v_mem, pulse v_valid, evaluate spike. Go to IDLE.
- Latency and throughput:
  - Inputs are sampled at E0; v_mem, v_valid and spike update at E3.
  - in_ready is low from E0 to E3, so the next accept is at E4.
  - Throughput is one step per 4 cycles.
  - in_valid while in_ready=0 is ignored; upstream holds its data.
- Spike rule: spike=1 iff old v_mem < SPIKE_THRESH, v_new ≥ SPIKE_THRESH, and the refractory counter is 0. On spike, the counter loads REFRACT_STEPS.
- Refractory counter: decrements by 1 on each accepted step that does not spike, saturating at 0. Integration continues normally during refractory.
- Arithmetic rules:
  - All saturation is to [−32768, 32767] before the clamp; truncation toward −∞ by the arithmetic shift.
  - dt=0 yields dv=0.
- Reset mid-operation: rst in any state forces the reset values on the next edge. No v_valid is produced for the aborted step.

Decomposition:
- Package hh_fixed_pkg holds:
  - Q8.8 format constants: FRAC_BITS=8, Q_ONE=256.
  - Saturation limits.
  - The state enum {IDLE,SUM,SCALE,UPDATE}.
  - Default V_REST, V_MIN and V_MAX values, shared with the gating and current stages.
- One sub-module: sat_mul_q88, a signed 16×16 multiply followed by >>>FRAC_BITS and saturation to 16 bits. It is shared by SCALE and UPDATE and is combinational.

Test Plan:
- Reset: assert rst for 2 cycles → v_mem=0xBF00 (−16640), in_ready=1, v_valid=0, spike=0, refractory=0.
- Zero net current: all currents 0, dt=0x0019 → v_valid at E3, v_mem stays −16640, spike=0, in_ready returns 1 after E3.
- Step, threshold crossing and clamp, with i_ext=0x4000 and others 0, dt=0x0100:
  - Step 1 → v_mem=−256, no spike.
  - Step 2 → v_mem=16128, spike=1, refractory=1.
  - Step 3 → v_mem clamped to 20480, spike=0.
- Saturation: i_ext=0x7FFF, i_na=i_k=i_leak=0x8000, dt=0x0100 → net saturates to 32767, dv=32767, v_mem clamps to V_MAX=20480.
- Refractory: after the spike in the step scenario, drive v below 0 with i_na=0x6000 and re-cross within 4 steps → no spike. Re-cross after the counter reaches 0 → spike=1.
- Reset mid-step: accept at E0, assert rst at E1 → v_mem=V_REST, no v_valid at E3, in_ready=1 after reset deasserts.

Source files
------------

// File: rtl/hh_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the Hodgkin-Huxley neuron datapath:
// format constants, saturation limits, membrane defaults and the
// integrator's step-sequencing states.
package hh_fixed_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int Q_ONE     = 256;

  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

  // Membrane potential defaults in Q8.8 mV, shared with gating/current stages.
  localparam logic signed [DATA_W-1:0] V_REST_DEF = -16'sd16640;  // -65.0
  localparam logic signed [DATA_W-1:0] V_MIN_DEF  = -16'sd25600;  // -100.0
  localparam logic signed [DATA_W-1:0] V_MAX_DEF  = 16'sd20480;   // +80.0

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    SCALE,
    UPDATE
  } state_t;

endpackage

// File: rtl/sat_mul_q88.sv
// Combinational Q8.8 multiply: signed a times unsigned b, arithmetic shift
// right by FRAC_BITS (truncation toward -inf), saturated to 16-bit signed.
module sat_mul_q88
  import hh_fixed_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_i,
  input  logic        [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_o
);

  logic signed [2*DATA_W:0] a_ext;
  logic signed [2*DATA_W:0] b_ext;
  logic signed [2*DATA_W:0] prod;
  logic signed [2*DATA_W:0] shifted;

  function automatic logic signed [DATA_W-1:0] sat_prod(input logic signed [2*DATA_W:0] x);
    if (x > 33'sd32767) begin
      return Q_MAX;
    end else if (x < -33'sd32768) begin
      return Q_MIN;
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

  // b is zero-extended so dt and INV_CM keep their full unsigned range.
  always_comb begin
    a_ext   = {{(DATA_W+1){a_i[DATA_W-1]}}, a_i};
    b_ext   = {{(DATA_W+1){1'b0}}, b_i};
    prod    = a_ext * b_ext;
    shifted = prod >>> FRAC_BITS;
    p_o     = sat_prod(shifted);
  end

endmodule

// File: rtl/membrane_integrator.sv
// Membrane potential integrator: sums ionic currents against the stimulus,
// applies one forward-Euler step V += net*dt/C_m, clamps V, and flags
// upward threshold crossings with a refractory hold-off.
module membrane_integrator
  import hh_fixed_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] V_REST        = V_REST_DEF,
  parameter logic signed [DATA_W-1:0] V_MIN         = V_MIN_DEF,
  parameter logic signed [DATA_W-1:0] V_MAX         = V_MAX_DEF,
  parameter logic signed [DATA_W-1:0] SPIKE_THRESH  = 16'sd0,
  parameter logic        [DATA_W-1:0] INV_CM        = 16'(Q_ONE),
  parameter int                       REFRACT_STEPS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] i_na,
  input  logic signed [DATA_W-1:0] i_k,
  input  logic signed [DATA_W-1:0] i_leak,
  input  logic signed [DATA_W-1:0] i_ext,
  input  logic        [DATA_W-1:0] dt,
  output logic signed [DATA_W-1:0] v_mem,
  output logic                     v_valid,
  output logic                     spike,
  output logic                     refractory
);

  localparam int CNT_W = $clog2(REFRACT_STEPS + 1);

  // Control state
  state_t                     state_q;
  logic                       in_ready_q;
  logic                       v_valid_q;
  logic                       spike_q;
  logic signed [DATA_W-1:0]   v_mem_q;
  logic        [CNT_W-1:0]    cnt_q;

  // Datapath registers (not reset: only consumed after a fresh capture)
  logic signed [DATA_W-1:0]   ext_p0, na_p0, k_p0, leak_p0;
  logic        [DATA_W-1:0]   dt_p0;
  logic signed [DATA_W-1:0]   net_p1;
  logic signed [DATA_W-1:0]   prod_p2;

  logic                       accept;
  logic                       use_upd;
  logic signed [DATA_W-1:0]   mul_a;
  logic        [DATA_W-1:0]   mul_b;
  logic signed [DATA_W-1:0]   mul_out;
  logic signed [DATA_W+1:0]   net_sum;
  logic signed [DATA_W:0]     v_sum;
  logic signed [DATA_W-1:0]   v_mem_d;
  logic                       spike_d;
  logic        [CNT_W-1:0]    cnt_d;

  function automatic logic signed [DATA_W+1:0] sx18(input logic signed [DATA_W-1:0] x);
    return {{2{x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [DATA_W:0] sx17(input logic signed [DATA_W-1:0] x);
    return {x[DATA_W-1], x};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat18(input logic signed [DATA_W+1:0] x);
    if (x > 18'sd32767) begin
      return Q_MAX;
    end else if (x < -18'sd32768) begin
      return Q_MIN;
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp_v(input logic signed [DATA_W:0] x);
    if (x > sx17(V_MAX)) begin
      return V_MAX;
    end else if (x < sx17(V_MIN)) begin
      return V_MIN;
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

  assign accept  = in_valid && in_ready_q && (state_q == IDLE);
  assign use_upd = (state_q == UPDATE);

  // One multiplier serves both the dt scaling and the 1/C_m scaling.
  assign mul_a = use_upd ? prod_p2 : net_p1;
  assign mul_b = use_upd ? INV_CM  : dt_p0;

  sat_mul_q88 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_out)
  );

  // Net current, next membrane potential, spike decision and refractory count.
  always_comb begin
    net_sum = sx18(ext_p0) - sx18(na_p0) - sx18(k_p0) - sx18(leak_p0);
    v_sum   = sx17(v_mem_q) + sx17(mul_out);
    v_mem_d = clamp_v(v_sum);
    spike_d = (v_mem_q < SPIKE_THRESH) && (v_mem_d >= SPIKE_THRESH) && (cnt_q == '0);
    if (spike_d) begin
      cnt_d = CNT_W'(REFRACT_STEPS);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Datapath stages: capture, sum, scale by dt.
  always_ff @(posedge clk) begin
    // p0: capture the step's currents and dt
    if (accept) begin
      ext_p0  <= i_ext;
      na_p0   <= i_na;
      k_p0    <= i_k;
      leak_p0 <= i_leak;
      dt_p0   <= dt;
    end
    // p1: saturated net current
    if (state_q == SUM) begin
      net_p1 <= sat18(net_sum);
    end
    // p2: net current scaled by dt
    if (state_q == SCALE) begin
      prod_p2 <= mul_out;
    end
  end

  // Step sequencer with registered handshake, membrane state and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      v_valid_q  <= 1'b0;
      spike_q    <= 1'b0;
      v_mem_q    <= V_REST;
      cnt_q      <= '0;
    end else begin
      v_valid_q <= 1'b0;
      spike_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            state_q    <= SUM;
          end
        end
        SUM:   state_q <= SCALE;
        SCALE: state_q <= UPDATE;
        UPDATE: begin
          v_mem_q    <= v_mem_d;
          v_valid_q  <= 1'b1;
          spike_q    <= spike_d;
          cnt_q      <= cnt_d;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign v_mem      = v_mem_q;
  assign v_valid    = v_valid_q;
  assign spike      = spike_q;
  assign refractory = (cnt_q != '0);

endmodule
